// File: rtl/axil_reg_bank_pkg.sv
// axil_reg_bank_pkg
// Shared types and constants for the AXI4-Lite register bank.
// Contents:
//   wr_state_t / rd_state_t : write and read channel FSM states
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   axil_req_t / axil_resp_t: default 32-bit AXI4-Lite request/response structs
package axil_reg_bank_pkg;

    localparam int unsigned AXIL_ADDR_WIDTH = 32;
    localparam int unsigned AXIL_DATA_WIDTH = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    typedef struct packed {
        logic [AXIL_ADDR_WIDTH-1:0] addr;
        logic [2:0]                 prot;
    } axil_ax_t;

    typedef struct packed {
        logic [AXIL_DATA_WIDTH-1:0]   data;
        logic [AXIL_DATA_WIDTH/8-1:0] strb;
    } axil_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } axil_b_t;

    typedef struct packed {
        logic [AXIL_DATA_WIDTH-1:0] data;
        logic [1:0]                 resp;
    } axil_r_t;

    typedef struct packed {
        axil_ax_t aw;
        logic     aw_valid;
        axil_w_t  w;
        logic     w_valid;
        logic     b_ready;
        axil_ax_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axil_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        axil_b_t b;
        logic    b_valid;
        logic    ar_ready;
        axil_r_t r;
        logic    r_valid;
    } axil_resp_t;

endpackage

// File: rtl/axil_reg_bank_decode.sv
// axil_reg_bank_decode
// Combinational address decoder: turns a byte address into a register index
// and an error flag (out of range, plus misalignment when the optional
// alignment check is built in via `define AXIL_REG_BANK_ALIGN_CHECK_EN).
// Ports:
//   addr : byte address from AW or AR
//   idx  : register index, addr[log2(DATA_WIDTH/8) +: log2(NUM_REGS)]
//   err  : access must be answered with SLVERR and have no side effect
module axil_reg_bank_decode
    import axil_reg_bank_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 8
) (
    input  logic [ADDR_WIDTH-1:0]       addr,
    output logic [$clog2(NUM_REGS)-1:0] idx,
    output logic                        err
);

    localparam int unsigned OFF_W = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    logic range_err;

    // Any set bit above the index field puts the address at or beyond
    // NUM_REGS*DATA_WIDTH/8, since NUM_REGS is a power of two.
    assign idx       = addr[OFF_W +: IDX_W];
    assign range_err = |addr[ADDR_WIDTH-1:OFF_W+IDX_W];

`ifdef AXIL_REG_BANK_ALIGN_CHECK_EN
    assign err = range_err | (|addr[OFF_W-1:0]);
`else
    // Byte-offset bits are intentionally ignored in this build.
    logic unused_low;
    assign unused_low = ^addr[OFF_W-1:0];
    assign err        = range_err;
`endif

endmodule

// File: rtl/axil_reg_bank.sv
// axil_reg_bank
// AXI4-Lite slave exposing NUM_REGS registers of DATA_WIDTH bits. Write and
// read channels run independent FSMs concurrently. Optional alignment
// checking is enabled with `define AXIL_REG_BANK_ALIGN_CHECK_EN.
// Ports:
//   axi_clk_i  : sole clock, rising edge
//   axi_rst_i  : synchronous active-high reset
//   axi_req_i  : AXI4-Lite request (aw, w, ar, valids, b_ready, r_ready)
//   axi_resp_o : AXI4-Lite response (b, r, valids, readies)
//   reg_q_o    : all register values, register k at [k*DATA_WIDTH +: DATA_WIDTH]
//   reg_wr_o   : one-cycle pulse per register written
module axil_reg_bank
    import axil_reg_bank_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 8,
    parameter type         axi_req_t  = axil_req_t,
    parameter type         axi_resp_t = axil_resp_t
) (
    input  logic                           axi_clk_i,
    input  logic                           axi_rst_i,
    input  axi_req_t                       axi_req_i,
    output axi_resp_t                      axi_resp_o,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o,
    output logic [NUM_REGS-1:0]            reg_wr_o
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = $clog2(NUM_REGS);

    wr_state_t             wr_state;
    logic                  aw_ready_q, w_ready_q, b_valid_q;
    logic [1:0]            b_resp_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   reg_wr_q;

    rd_state_t             rd_state;
    logic                  ar_ready_q, r_valid_q;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [1:0]            r_resp_q;

    logic                  aw_hs, w_hs, ar_hs, wr_commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  wr_err, rd_err;

    // Protection bits carry no meaning for this bank.
    logic unused_prot;
    assign unused_prot = ^{axi_req_i.aw.prot, axi_req_i.ar.prot};

    assign aw_hs = aw_ready_q & axi_req_i.aw_valid;
    assign w_hs  = w_ready_q  & axi_req_i.w_valid;
    assign ar_hs = ar_ready_q & axi_req_i.ar_valid;

    // Pick the address/data of the write being completed: a beat latched
    // earlier comes from its holding register, the beat arriving now comes
    // straight from the bus. wr_commit marks the edge that enters WR_RESP.
    always_comb begin
        wr_addr   = (wr_state == WR_HAVE_AW) ? aw_addr_q : axi_req_i.aw.addr;
        wr_data   = (wr_state == WR_HAVE_W)  ? w_data_q  : axi_req_i.w.data;
        wr_strb   = (wr_state == WR_HAVE_W)  ? w_strb_q  : axi_req_i.w.strb;
        wr_commit = ((wr_state == WR_IDLE)    && aw_hs && w_hs) ||
                    ((wr_state == WR_HAVE_AW) && w_hs) ||
                    ((wr_state == WR_HAVE_W)  && aw_hs);
    end

    axil_reg_bank_decode #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REGS  (NUM_REGS)
    ) u_wr_decode (
        .addr(wr_addr),
        .idx (wr_idx),
        .err (wr_err)
    );

    axil_reg_bank_decode #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REGS  (NUM_REGS)
    ) u_rd_decode (
        .addr(axi_req_i.ar.addr),
        .idx (rd_idx),
        .err (rd_err)
    );

    // Write FSM plus the register array. The registers are updated, and the
    // write pulse raised, on the same edge that moves into WR_RESP, so
    // b_valid appears one cycle after the last beat. Readies and b_valid are
    // registered alongside the state; reset drops any half-collected beat.
    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i) begin
            wr_state   <= WR_IDLE;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b1;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            reg_wr_q   <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else begin
            reg_wr_q <= '0;
            if (wr_commit) begin
                b_resp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
                if (!wr_err) begin
                    reg_wr_q[wr_idx] <= 1'b1;
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wr_strb[b]) begin
                            regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                        end
                    end
                end
            end
            case (wr_state)
                WR_IDLE: begin
                    if (aw_hs && w_hs) begin
                        wr_state   <= WR_RESP;
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b0;
                        b_valid_q  <= 1'b1;
                    end else if (aw_hs) begin
                        wr_state   <= WR_HAVE_AW;
                        aw_addr_q  <= axi_req_i.aw.addr;
                        aw_ready_q <= 1'b0;
                    end else if (w_hs) begin
                        wr_state  <= WR_HAVE_W;
                        w_data_q  <= axi_req_i.w.data;
                        w_strb_q  <= axi_req_i.w.strb;
                        w_ready_q <= 1'b0;
                    end
                end
                WR_HAVE_AW: begin
                    if (w_hs) begin
                        wr_state  <= WR_RESP;
                        w_ready_q <= 1'b0;
                        b_valid_q <= 1'b1;
                    end
                end
                WR_HAVE_W: begin
                    if (aw_hs) begin
                        wr_state   <= WR_RESP;
                        aw_ready_q <= 1'b0;
                        b_valid_q  <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (axi_req_i.b_ready) begin
                        wr_state   <= WR_IDLE;
                        b_valid_q  <= 1'b0;
                        aw_ready_q <= 1'b1;
                        w_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    wr_state   <= WR_IDLE;
                    aw_ready_q <= 1'b1;
                    w_ready_q  <= 1'b1;
                    b_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    // Read FSM. The register array is sampled on the AR handshake edge, so a
    // write landing on that same edge is not yet visible (pre-write value).
    // r.data/r.resp only change on a handshake, keeping them stable while
    // the master holds off r_ready.
    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i) begin
            rd_state   <= RD_IDLE;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        rd_state   <= RD_RESP;
                        r_data_q   <= rd_err ? '0 : regs[rd_idx];
                        r_resp_q   <= rd_err ? RESP_SLVERR : RESP_OKAY;
                        ar_ready_q <= 1'b0;
                        r_valid_q  <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (axi_req_i.r_ready) begin
                        rd_state   <= RD_IDLE;
                        r_valid_q  <= 1'b0;
                        ar_ready_q <= 1'b1;
                    end
                end
                default: begin
                    rd_state   <= RD_IDLE;
                    r_valid_q  <= 1'b0;
                    ar_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Assemble the response struct and flatten the register array.
    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = aw_ready_q;
        axi_resp_o.w_ready  = w_ready_q;
        axi_resp_o.b_valid  = b_valid_q;
        axi_resp_o.b.resp   = b_resp_q;
        axi_resp_o.ar_ready = ar_ready_q;
        axi_resp_o.r_valid  = r_valid_q;
        axi_resp_o.r.data   = r_data_q;
        axi_resp_o.r.resp   = r_resp_q;
        reg_q_o             = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            reg_q_o[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
        end
    end

    assign reg_wr_o = reg_wr_q;

endmodule

// File: tb/tb_axil_reg_bank.sv
// tb_axil_reg_bank
// Directed self-checking bench for axil_reg_bank (default 32-bit, 8 regs).
// Expectations for the 0x06 read follow AXIL_REG_BANK_ALIGN_CHECK_EN.
module tb_axil_reg_bank;
    import axil_reg_bank_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    axil_req_t    axi_req;
    axil_resp_t   axi_resp;
    logic [255:0] reg_q;
    logic [7:0]   reg_wr;

    int total = 0;
    int bad   = 0;

    axil_reg_bank #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .NUM_REGS  (8),
        .axi_req_t (axil_req_t),
        .axi_resp_t(axil_resp_t)
    ) dut (
        .axi_clk_i (clk),
        .axi_rst_i (rst),
        .axi_req_i (axi_req),
        .axi_resp_o(axi_resp),
        .reg_q_o   (reg_q),
        .reg_wr_o  (reg_wr)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive every request field at once.
    task automatic applyStimulus(input logic aw_v, input logic [31:0] aw_a,
                                 input logic w_v, input logic [31:0] w_d, input logic [3:0] w_s,
                                 input logic ar_v, input logic [31:0] ar_a,
                                 input logic b_r, input logic r_r);
        axi_req          = '0;
        axi_req.aw_valid = aw_v;
        axi_req.aw.addr  = aw_a;
        axi_req.w_valid  = w_v;
        axi_req.w.data   = w_d;
        axi_req.w.strb   = w_s;
        axi_req.ar_valid = ar_v;
        axi_req.ar.addr  = ar_a;
        axi_req.b_ready  = b_r;
        axi_req.r_ready  = r_r;
    endtask

    function automatic logic [31:0] regAt(input int k);
        return reg_q[k*32 +: 32];
    endfunction

    // AW and W presented together; returns b.resp and the reg_wr_o pulse
    // seen in the b_valid cycle.
    task automatic axiWrite(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] bresp, output logic [7:0] pulse);
        int n = 0;
        applyStimulus(1'b1, a, 1'b1, d, s, 1'b0, 32'h0, 1'b0, 1'b0);
        while (!(axi_resp.aw_ready && axi_resp.w_ready) && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) checkOutput({tag, " accept timeout"}, 64'd0, 64'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput({tag, " b_valid"}, 64'(axi_resp.b_valid), 64'd1);
        bresp = axi_resp.b.resp;
        pulse = reg_wr;
        axi_req.b_ready = 1'b1;
        tick();
        axi_req.b_ready = 1'b0;
    endtask

    task automatic axiRead(input string tag, input logic [31:0] a,
                           output logic [31:0] data, output logic [1:0] rresp);
        int n = 0;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, a, 1'b0, 1'b0);
        while (!axi_resp.ar_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) checkOutput({tag, " accept timeout"}, 64'd0, 64'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput({tag, " r_valid"}, 64'(axi_resp.r_valid), 64'd1);
        data  = axi_resp.r.data;
        rresp = axi_resp.r.resp;
        axi_req.r_ready = 1'b1;
        tick();
        axi_req.r_ready = 1'b0;
    endtask

    initial begin
        logic [1:0]   resp;
        logic [7:0]   pulse;
        logic [31:0]  data;
        logic [255:0] snap;

        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        checkOutput("rst regs zero", 64'(reg_q == '0), 64'd1);
        checkOutput("rst b_valid", 64'(axi_resp.b_valid), 64'd0);
        checkOutput("rst r_valid", 64'(axi_resp.r_valid), 64'd0);
        checkOutput("rst reg_wr", 64'(reg_wr), 64'd0);
        checkOutput("rst r_data", 64'(axi_resp.r.data), 64'd0);
        rst = 1'b0;
        checkOutput("post-rst aw_ready", 64'(axi_resp.aw_ready), 64'd1);
        checkOutput("post-rst ar_ready", 64'(axi_resp.ar_ready), 64'd1);

        // Write then read back register 1
        axiWrite("wr04", 32'h04, 32'hDEADBEEF, 4'hF, resp, pulse);
        checkOutput("wr04 bresp", 64'(resp), 64'd0);
        checkOutput("wr04 pulse", 64'(pulse), 64'h02);
        checkOutput("wr04 pulse once", 64'(reg_wr), 64'h00);
        checkOutput("wr04 reg1", 64'(regAt(1)), 64'hDEADBEEF);
        axiRead("rd04", 32'h04, data, resp);
        checkOutput("rd04 data", 64'(data), 64'hDEADBEEF);
        checkOutput("rd04 rresp", 64'(resp), 64'd0);

        // Zero strobe: still pulses, leaves contents alone
        axiWrite("strb0", 32'h04, 32'hFFFFFFFF, 4'h0, resp, pulse);
        checkOutput("strb0 pulse", 64'(pulse), 64'h02);
        checkOutput("strb0 reg1", 64'(regAt(1)), 64'hDEADBEEF);

        // W three cycles ahead of AW, partial strobe over a preloaded reg
        axiWrite("pre08", 32'h08, 32'hAAAAAAAA, 4'hF, resp, pulse);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h11223344, 4'b0011, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("wfirst w_ready", 64'(axi_resp.w_ready), 64'd0);
        checkOutput("wfirst aw_ready", 64'(axi_resp.aw_ready), 64'd1);
        tick();
        tick();
        checkOutput("wfirst b_valid early", 64'(axi_resp.b_valid), 64'd0);
        checkOutput("wfirst reg2 early", 64'(regAt(2)), 64'hAAAAAAAA);
        applyStimulus(1'b1, 32'h08, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("wfirst b_valid", 64'(axi_resp.b_valid), 64'd1);
        checkOutput("wfirst reg2", 64'(regAt(2)), 64'hAAAA3344);
        checkOutput("wfirst pulse", 64'(reg_wr), 64'h04);
        axi_req.b_ready = 1'b1;
        tick();
        axi_req.b_ready = 1'b0;

        // Out of range write and read
        snap = reg_q;
        axiWrite("wr20", 32'h20, 32'h12345678, 4'hF, resp, pulse);
        checkOutput("wr20 bresp", 64'(resp), 64'h2);
        checkOutput("wr20 pulse", 64'(pulse), 64'h00);
        checkOutput("wr20 regs kept", 64'(reg_q == snap), 64'd1);
        axiRead("rd20", 32'h20, data, resp);
        checkOutput("rd20 data", 64'(data), 64'h0);
        checkOutput("rd20 rresp", 64'(resp), 64'h2);

        // Back-pressure on both response channels with a second request
        // held on the bus; the second one also reads the register it writes
        applyStimulus(1'b1, 32'h0C, 1'b1, 32'h5A5A0001, 4'hF, 1'b1, 32'h04, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h0C, 1'b1, 32'h00000077, 4'hF, 1'b1, 32'h0C, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp%0d b_valid", i), 64'(axi_resp.b_valid), 64'd1);
            checkOutput($sformatf("bp%0d r_valid", i), 64'(axi_resp.r_valid), 64'd1);
            checkOutput($sformatf("bp%0d r_data", i), 64'(axi_resp.r.data), 64'hDEADBEEF);
            checkOutput($sformatf("bp%0d readies", i),
                        64'({axi_resp.aw_ready, axi_resp.w_ready, axi_resp.ar_ready}), 64'd0);
            tick();
        end
        checkOutput("bp reg3", 64'(regAt(3)), 64'h5A5A0001);
        axi_req.b_ready = 1'b1;
        axi_req.r_ready = 1'b1;
        tick();
        axi_req.b_ready = 1'b0;
        axi_req.r_ready = 1'b0;
        checkOutput("bp2 readies", 64'({axi_resp.aw_ready, axi_resp.w_ready, axi_resp.ar_ready}), 64'h7);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("bp2 b_valid", 64'(axi_resp.b_valid), 64'd1);
        checkOutput("bp2 r_valid", 64'(axi_resp.r_valid), 64'd1);
        checkOutput("bp2 r_data prewrite", 64'(axi_resp.r.data), 64'h5A5A0001);
        checkOutput("bp2 reg3", 64'(regAt(3)), 64'h00000077);
        checkOutput("bp2 pulse", 64'(reg_wr), 64'h08);
        axi_req.b_ready = 1'b1;
        axi_req.r_ready = 1'b1;
        tick();
        axi_req.b_ready = 1'b0;
        axi_req.r_ready = 1'b0;
        checkOutput("bp2 pulse once", 64'(reg_wr), 64'h00);

        // Reset in the middle of a write
        applyStimulus(1'b1, 32'h14, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("mid aw_ready", 64'(axi_resp.aw_ready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid regs cleared", 64'(reg_q == '0), 64'd1);
        checkOutput("mid idle readies", 64'({axi_resp.aw_ready, axi_resp.w_ready}), 64'h3);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h00000099, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("mid have_w readies", 64'({axi_resp.aw_ready, axi_resp.w_ready}), 64'h2);
        checkOutput("mid b_valid", 64'(axi_resp.b_valid), 64'd0);
        checkOutput("mid reg5", 64'(regAt(5)), 64'h0);
        applyStimulus(1'b1, 32'h18, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("mid2 b_valid", 64'(axi_resp.b_valid), 64'd1);
        checkOutput("mid2 reg6", 64'(regAt(6)), 64'h99);
        checkOutput("mid2 reg5", 64'(regAt(5)), 64'h0);
        checkOutput("mid2 pulse", 64'(reg_wr), 64'h40);
        axi_req.b_ready = 1'b1;
        tick();
        axi_req.b_ready = 1'b0;

        // Unaligned read
        axiWrite("wr04b", 32'h04, 32'h01234567, 4'hF, resp, pulse);
        axiRead("rd06", 32'h06, data, resp);
`ifdef AXIL_REG_BANK_ALIGN_CHECK_EN
        checkOutput("rd06 rresp", 64'(resp), 64'h2);
        checkOutput("rd06 data", 64'(data), 64'h0);
`else
        checkOutput("rd06 rresp", 64'(resp), 64'h0);
        checkOutput("rd06 data", 64'(data), 64'h01234567);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
